// File: rtl/tl_stim_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_stim_sequencer_pkg
// Description : Shared definitions for the table-driven TileLink stimulus
//               sequencer: transaction type codes, FSM state encoding and a
//               saturating counter helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tl_stim_sequencer_pkg;

  // Transaction type codes as stored in the table and driven on transaction_type
  localparam logic [1:0] TX_GET        = 2'b00;
  localparam logic [1:0] TX_PUTFULL    = 2'b01;
  localparam logic [1:0] TX_PUTPARTIAL = 2'b10;
  localparam logic [1:0] TX_RSVD       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Result counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_stim_table.sv
`default_nettype none
// ============================================================================
// Module      : tl_stim_table
// Description : DEPTH-entry transaction table. One synchronous write port,
//               one combinational read port. Contents are not reset.
// Ports       : clk                      - clock
//               we / wr_idx / wr_*       - write strobe, index, entry fields
//               rd_idx / rd_*            - read index, entry fields
// Revision    : 1.0 - initial release
// ============================================================================
module tl_stim_table
  import tl_stim_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 8,
  parameter int SIZE_W     = 3,
  parameter int SOURCE_W   = 4,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [1:0]              wr_type,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [SIZE_W-1:0]       wr_size,
  input  logic [SOURCE_W-1:0]     wr_source,
  input  logic [DATA_BYTES*8-1:0] wr_data,
  input  logic [DATA_BYTES-1:0]   wr_mask,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [1:0]              rd_type,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic [SIZE_W-1:0]       rd_size,
  output logic [SOURCE_W-1:0]     rd_source,
  output logic [DATA_BYTES*8-1:0] rd_data,
  output logic [DATA_BYTES-1:0]   rd_mask
);

  localparam int ENTRY_W = 2 + ADDR_W + SIZE_W + SOURCE_W + DATA_BYTES * 9;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Out-of-range indices (non power-of-two DEPTH) are dropped on write
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wr_idx} < DEPTH_L)) begin
      mem[wr_idx] <= {wr_type, wr_addr, wr_size, wr_source, wr_data, wr_mask};
    end
  end

  assign {rd_type, rd_addr, rd_size, rd_source, rd_data, rd_mask} = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/tl_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tl_stim_sequencer
// Description : Table-driven TileLink stimulus sequencer. Issues the first
//               num_entries table entries one at a time, loops times, with
//               GAP_CYCLES idle cycles between transactions. GET responses
//               are checked under the entry byte mask; a missing response
//               aborts the sequence with timeout_err.
// Ports       : clk, rst_n (sync, active low)
//               cfg_*          - table programming (ignored while busy)
//               run, num_entries, loops, mem_init_done - sequence control
//               start_transaction + request fields -> bench driver
//               read_data, transaction_done        <- bench driver
//               busy, test_done, pass_count, fail_count, timeout_err, cur_idx
// Revision    : 1.0 - initial release
// ============================================================================
module tl_stim_sequencer
  import tl_stim_sequencer_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_BYTES     = 8,
  parameter int SIZE_W         = 3,
  parameter int SOURCE_W       = 4,
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  // Derived from DEPTH; not intended to be overridden
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [1:0]              cfg_type,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [SIZE_W-1:0]       cfg_size,
  input  logic [SOURCE_W-1:0]     cfg_source,
  input  logic [DATA_BYTES*8-1:0] cfg_data,
  input  logic [DATA_BYTES-1:0]   cfg_mask,
  input  logic                    run,
  input  logic [IDX_W:0]          num_entries,
  input  logic [7:0]              loops,
  input  logic                    mem_init_done,
  output logic                    start_transaction,
  output logic [1:0]              transaction_type,
  output logic [ADDR_W-1:0]       address,
  output logic [SIZE_W-1:0]       size,
  output logic [SOURCE_W-1:0]     source,
  output logic [DATA_BYTES*8-1:0] write_data,
  output logic [DATA_BYTES-1:0]   write_mask,
  input  logic [DATA_BYTES*8-1:0] read_data,
  input  logic                    transaction_done,
  output logic                    busy,
  output logic                    test_done,
  output logic [15:0]             pass_count,
  output logic [15:0]             fail_count,
  output logic                    timeout_err,
  output logic [IDX_W-1:0]        cur_idx
);

  localparam int NUM_W = IDX_W + 1;
  localparam logic [NUM_W-1:0] DEPTH_N = NUM_W'(DEPTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e                  state;
  logic [NUM_W-1:0]        r_num;
  logic [7:0]              r_loops;
  logic [7:0]              r_loop_cnt;
  logic [TMR_W-1:0]        r_timer;
  logic [GAP_W-1:0]        r_gap_cnt;

  logic [IDX_W-1:0]        w_rd_idx;
  logic [1:0]              w_e_type;
  logic [ADDR_W-1:0]       w_e_addr;
  logic [SIZE_W-1:0]       w_e_size;
  logic [SOURCE_W-1:0]     w_e_source;
  logic [DATA_BYTES*8-1:0] w_e_data;
  logic [DATA_BYTES-1:0]   w_e_mask;
  logic [NUM_W-1:0]        w_num_clamped;
  logic [7:0]              w_loops_eff;
  logic                    w_more_entries;
  logic                    w_more_loops;
  logic                    w_gap_over;
  logic                    w_load;
  logic [DATA_BYTES-1:0]   w_byte_ok;
  logic                    w_get_ok;

  assign busy = (state != ST_IDLE) && (state != ST_DONE);

  assign w_num_clamped  = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
  assign w_loops_eff    = (loops == 8'd0) ? 8'd1 : loops;
  assign w_more_entries = {1'b0, cur_idx} < (r_num - NUM_W'(1));
  assign w_more_loops   = r_loop_cnt < (r_loops - 8'd1);
  assign w_gap_over     = (state == ST_GAP) && (r_gap_cnt >= GAP_LAST);

  // The entry is latched onto the outputs on the edge that enters ISSUE, so
  // the table is read at the index cur_idx is about to take.
  assign w_rd_idx = (state == ST_GAP) ? (w_more_entries ? cur_idx + IDX_W'(1) : '0) : cur_idx;
  assign w_load   = ((state == ST_WAIT_INIT) && mem_init_done) ||
                    (w_gap_over && (w_more_entries || w_more_loops));

  // Unmasked bytes always compare equal, so a zero mask means "no check"
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_byte
    assign w_byte_ok[i] = ~write_mask[i] | (read_data[8*i +: 8] == write_data[8*i +: 8]);
  end
  assign w_get_ok = &w_byte_ok;

  tl_stim_table #(
    .ADDR_W     (ADDR_W),
    .DATA_BYTES (DATA_BYTES),
    .SIZE_W     (SIZE_W),
    .SOURCE_W   (SOURCE_W),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk       (clk),
    .we        (cfg_we && !busy),
    .wr_idx    (cfg_idx),
    .wr_type   (cfg_type),
    .wr_addr   (cfg_addr),
    .wr_size   (cfg_size),
    .wr_source (cfg_source),
    .wr_data   (cfg_data),
    .wr_mask   (cfg_mask),
    .rd_idx    (w_rd_idx),
    .rd_type   (w_e_type),
    .rd_addr   (w_e_addr),
    .rd_size   (w_e_size),
    .rd_source (w_e_source),
    .rd_data   (w_e_data),
    .rd_mask   (w_e_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      start_transaction <= 1'b0;
      transaction_type  <= '0;
      address           <= '0;
      size              <= '0;
      source            <= '0;
      write_data        <= '0;
      write_mask        <= '1;
      test_done         <= 1'b0;
      pass_count        <= '0;
      fail_count        <= '0;
      timeout_err       <= 1'b0;
      cur_idx           <= '0;
      r_num             <= '0;
      r_loops           <= '0;
      r_loop_cnt        <= '0;
      r_timer           <= '0;
      r_gap_cnt         <= '0;
    end else begin
      start_transaction <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (run) begin
            pass_count  <= '0;
            fail_count  <= '0;
            timeout_err <= 1'b0;
            cur_idx     <= '0;
            r_loop_cnt  <= '0;
            r_num       <= w_num_clamped;
            r_loops     <= w_loops_eff;
            if (num_entries == '0) begin
              test_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              test_done <= 1'b0;
              state     <= ST_WAIT_INIT;
            end
          end
        end

        ST_WAIT_INIT: begin
          if (mem_init_done) state <= ST_ISSUE;
        end

        ST_ISSUE: begin
          // Timer counts from the pulse cycle itself
          r_timer <= TMR_W'(1);
          if (transaction_type == TX_RSVD) begin
            fail_count <= sat_inc16(fail_count);
            r_gap_cnt  <= '0;
            state      <= ST_GAP;
          end else begin
            state <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (transaction_done) begin
            if ((transaction_type == TX_GET) && !w_get_ok) fail_count <= sat_inc16(fail_count);
            else                                           pass_count <= sat_inc16(pass_count);
            r_gap_cnt <= '0;
            state     <= ST_GAP;
          end else if (r_timer >= TMR_LAST) begin
            timeout_err <= 1'b1;
            fail_count  <= sat_inc16(fail_count);
            test_done   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_GAP: begin
          if (w_gap_over) begin
            if (w_more_entries) begin
              cur_idx <= cur_idx + IDX_W'(1);
              state   <= ST_ISSUE;
            end else if (w_more_loops) begin
              cur_idx    <= '0;
              r_loop_cnt <= r_loop_cnt + 8'd1;
              state      <= ST_ISSUE;
            end else begin
              test_done <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (w_load) begin
        transaction_type  <= w_e_type;
        address           <= w_e_addr;
        size              <= w_e_size;
        source            <= w_e_source;
        write_data        <= w_e_data;
        write_mask        <= w_e_mask;
        start_transaction <= (w_e_type != TX_RSVD);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_stim_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tl_stim_sequencer
// Description : Self-checking bench for tl_stim_sequencer. Expected requests
//               are queued from a shadow copy of the table when a sequence
//               is launched and compared with the pulses the DUT emits; a
//               small memory model answers the requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_stim_sequencer;
  import tl_stim_sequencer_pkg::*;

  localparam int ADDR_W = 32, DATA_BYTES = 8, SIZE_W = 3, SOURCE_W = 4;
  localparam int DEPTH = 16, GAP_CYCLES = 3, TIMEOUT_CYCLES = 16;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int DW = DATA_BYTES * 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [IDX_W-1:0]      cfg_idx = '0;
  logic [1:0]            cfg_type = '0;
  logic [ADDR_W-1:0]     cfg_addr = '0;
  logic [SIZE_W-1:0]     cfg_size = '0;
  logic [SOURCE_W-1:0]   cfg_source = '0;
  logic [DW-1:0]         cfg_data = '0;
  logic [DATA_BYTES-1:0] cfg_mask = '0;
  logic                  run = 1'b0;
  logic [IDX_W:0]        num_entries = '0;
  logic [7:0]            loops = '0;
  logic                  mem_init_done = 1'b1;
  logic                  start_transaction;
  logic [1:0]            transaction_type;
  logic [ADDR_W-1:0]     address;
  logic [SIZE_W-1:0]     size;
  logic [SOURCE_W-1:0]   source;
  logic [DW-1:0]         write_data;
  logic [DATA_BYTES-1:0] write_mask;
  logic [DW-1:0]         read_data = '0;
  logic                  transaction_done = 1'b0;
  logic                  busy, test_done, timeout_err;
  logic [15:0]           pass_count, fail_count;
  logic [IDX_W-1:0]      cur_idx;

  tl_stim_sequencer #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .SIZE_W(SIZE_W), .SOURCE_W(SOURCE_W),
    .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_type(cfg_type),
    .cfg_addr(cfg_addr), .cfg_size(cfg_size), .cfg_source(cfg_source), .cfg_data(cfg_data),
    .cfg_mask(cfg_mask), .run(run), .num_entries(num_entries), .loops(loops),
    .mem_init_done(mem_init_done), .start_transaction(start_transaction),
    .transaction_type(transaction_type), .address(address), .size(size), .source(source),
    .write_data(write_data), .write_mask(write_mask), .read_data(read_data),
    .transaction_done(transaction_done), .busy(busy), .test_done(test_done),
    .pass_count(pass_count), .fail_count(fail_count), .timeout_err(timeout_err),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]            t;
    logic [ADDR_W-1:0]     a;
    logic [SIZE_W-1:0]     s;
    logic [SOURCE_W-1:0]   src;
    logic [DW-1:0]         d;
    logic [DATA_BYTES-1:0] m;
    logic [IDX_W-1:0]      idx;
  } txn_t;

  txn_t          shadow [DEPTH];
  txn_t          exp_q[$];
  txn_t          obs_q[$];
  int            gap_q[$];
  logic [DW-1:0] mem [logic [ADDR_W-1:0]];

  int vectors = 0;
  int miscompares = 0;
  bit resp_on = 1'b1;
  int resp_lat = 2;
  int first_pulse, first_to;

  task automatic program_entry(input int i, input logic [1:0] ty, input logic [ADDR_W-1:0] ad,
                               input logic [DW-1:0] dt, input logic [DATA_BYTES-1:0] mk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IDX_W'(i); cfg_type = ty; cfg_addr = ad;
    cfg_size = 3'd3; cfg_source = SOURCE_W'(i); cfg_data = dt; cfg_mask = mk;
    shadow[i].t = ty; shadow[i].a = ad; shadow[i].s = 3'd3; shadow[i].src = SOURCE_W'(i);
    shadow[i].d = dt; shadow[i].m = mk; shadow[i].idx = IDX_W'(i);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Launches a sequence and acts as the bench driver / memory responder until
  // test_done, the cycle budget, or stop_after cycles past the first pulse.
  task automatic run_seq(input int budget, input int stop_after, output bit finished);
    int cd, last_done, stop_at;
    txn_t pend;
    logic [DW-1:0] cur;
    cd = 0; last_done = -1000; stop_at = -1; finished = 1'b0;
    first_pulse = -1; first_to = -1; pend = '0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      transaction_done = 1'b0;
      if (cyc == 0) mem_init_done = 1'b1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cur = mem.exists(pend.a) ? mem[pend.a] : '0;
          if (pend.t == TX_GET) begin
            read_data = cur;
          end else begin
            for (int b = 0; b < DATA_BYTES; b++)
              if (pend.m[b]) cur[8*b +: 8] = pend.d[8*b +: 8];
            mem[pend.a] = cur;
          end
          transaction_done = 1'b1;
          last_done = cyc;
        end
      end
      if (start_transaction === 1'b1) begin
        pend.t = transaction_type; pend.a = address; pend.s = size; pend.src = source;
        pend.d = write_data; pend.m = write_mask; pend.idx = cur_idx;
        obs_q.push_back(pend);
        gap_q.push_back(cyc - last_done);
        if (first_pulse < 0) first_pulse = cyc;
        if (resp_on) cd = resp_lat;
        if (stop_after >= 0 && stop_at < 0) stop_at = cyc + stop_after;
      end
      if (timeout_err === 1'b1 && first_to < 0) first_to = cyc;
      if (test_done === 1'b1) begin finished = 1'b1; break; end
      if (stop_at >= 0 && cyc >= stop_at) break;
      @(negedge clk);
    end
    transaction_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || start_transaction !== 1'b0 || test_done !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy/start/done/to=%b%b%b%b required 0000", busy, start_transaction, test_done, timeout_err);
    end
    vectors++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0 || cur_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: pass=%0d fail=%0d idx=%0d required 0 0 0", pass_count, fail_count, cur_idx);
    end
    vectors++;
    if ({transaction_type, address, size, source, write_data, write_mask} !== {{(2+ADDR_W+SIZE_W+SOURCE_W+DW){1'b0}}, 8'hFF}) begin
      miscompares++;
      $display("FAIL reset_fields: addr=%h data=%h mask=%h required 0 0 ff", address, write_data, write_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_put_get;
    bit fin;
    int n;
    txn_t o, e;
    program_entry(0, TX_PUTFULL, 32'h2000, 64'h11223344AABBCCDD, 8'hFF);
    program_entry(1, TX_GET,     32'h2000, 64'h11223344AABBCCDD, 8'hFF);
    num_entries = 5'd2; loops = 8'd1; resp_on = 1'b1; resp_lat = 2;
    exp_q.push_back(shadow[0]); exp_q.push_back(shadow[1]);
    run_seq(300, -1, fin);
    n = obs_q.size();
    vectors++;
    if (!fin || n != 2) begin miscompares++; $display("FAIL putget_pulses: finished=%0d pulses=%0d required 1 2", fin, n); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL putget_txn: got %h required %h", o, e); end
    end
    vectors++;
    if (pass_count !== 16'd2 || fail_count !== 16'd0 || test_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL putget_result: pass=%0d fail=%0d done=%b busy=%b required 2 0 1 0", pass_count, fail_count, test_done, busy);
    end
    obs_q.delete(); exp_q.delete(); gap_q.delete();
  endtask

  task automatic test_zero_entries;
    bit fin;
    num_entries = '0;
    run_seq(20, -1, fin);
    vectors++;
    if (!fin || obs_q.size() != 0 || pass_count !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_entries: finished=%0d pulses=%0d pass=%0d busy=%b required 1 0 0 0", fin, obs_q.size(), pass_count, busy);
    end
    obs_q.delete(); gap_q.delete();
  endtask

  task automatic test_masked_get;
    bit fin;
    txn_t o, e;
    program_entry(0, TX_GET, 32'h3000, 64'h00000000FFFFFFFF, 8'h0F);
    mem[32'h3000] = 64'hDEADBEEFFFFFFFFF;
    num_entries = 5'd1; loops = 8'd0;
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      if (pass_i == 1) mem[32'h3000] = 64'hDEADBEEFFFFFFFFE;
      exp_q.push_back(shadow[0]);
      run_seq(200, -1, fin);
      vectors++;
      if (!fin || obs_q.size() != 1) begin miscompares++; $display("FAIL mask_pulses: finished=%0d pulses=%0d required 1 1", fin, obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL mask_txn: got %h required %h", o, e); end
      end
      vectors++;
      if (pass_count !== ((pass_i == 0) ? 16'd1 : 16'd0) || fail_count !== ((pass_i == 0) ? 16'd0 : 16'd1)) begin
        miscompares++;
        $display("FAIL mask_result%0d: pass=%0d fail=%0d required %0d %0d", pass_i, pass_count, fail_count, 1 - pass_i, pass_i);
      end
      obs_q.delete(); exp_q.delete(); gap_q.delete();
    end
  endtask

  task automatic test_timeout;
    bit fin;
    int extra;
    txn_t o, e;
    program_entry(0, TX_GET,     32'h5000, 64'h0, 8'h00);
    program_entry(1, TX_PUTFULL, 32'h5008, 64'h1, 8'hFF);
    num_entries = 5'd2; loops = 8'd1; resp_on = 1'b0;
    exp_q.push_back(shadow[0]);
    run_seq(200, -1, fin);
    vectors++;
    if (!fin || obs_q.size() != 1) begin miscompares++; $display("FAIL timeout_pulses: finished=%0d pulses=%0d required 1 1", fin, obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL timeout_txn: got %h required %h", o, e); end
    end
    vectors++;
    if (first_to - first_pulse != TIMEOUT_CYCLES) begin
      miscompares++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", first_to - first_pulse, TIMEOUT_CYCLES);
    end
    vectors++;
    if (timeout_err !== 1'b1 || fail_count !== 16'd1 || pass_count !== 16'd0 || test_done !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_result: to=%b fail=%0d pass=%0d done=%b required 1 1 0 1", timeout_err, fail_count, pass_count, test_done);
    end
    extra = 0;
    repeat (30) begin @(negedge clk); if (start_transaction === 1'b1) extra++; end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL timeout_abort: extra pulses=%0d required 0", extra); end
    resp_on = 1'b1;
    obs_q.delete(); exp_q.delete(); gap_q.delete();
  endtask

  task automatic test_loops;
    bit fin;
    int g, n;
    txn_t o, e;
    program_entry(0, TX_PUTPARTIAL, 32'h4000, 64'h0102030405060708, 8'hFF);
    program_entry(1, TX_GET,        32'h4000, 64'h0102030405060708, 8'hFF);
    num_entries = 5'd2; loops = 8'd3; resp_lat = 3;
    repeat (3) begin exp_q.push_back(shadow[0]); exp_q.push_back(shadow[1]); end
    run_seq(1000, -1, fin);
    n = obs_q.size();
    vectors++;
    if (!fin || n != 6) begin miscompares++; $display("FAIL loops_pulses: finished=%0d pulses=%0d required 1 6", fin, n); end
    void'(gap_q.pop_front());
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front(); vectors++;
      if (g < GAP_CYCLES + 1) begin miscompares++; $display("FAIL loops_gap: cycles=%0d required >= %0d", g, GAP_CYCLES + 1); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL loops_txn: got %h required %h", o, e); end
    end
    vectors++;
    if (pass_count !== 16'd6 || fail_count !== 16'd0) begin
      miscompares++;
      $display("FAIL loops_result: pass=%0d fail=%0d required 6 0", pass_count, fail_count);
    end
    resp_lat = 2;
    obs_q.delete(); exp_q.delete(); gap_q.delete();
  endtask

  task automatic test_reset_mid;
    bit fin;
    txn_t o, e;
    program_entry(0, TX_PUTFULL, 32'h8000, 64'hCAFEF00D12345678, 8'h3C);
    num_entries = 5'd1; loops = 8'd1; resp_on = 1'b0;
    exp_q.push_back(shadow[0]);
    run_seq(100, 3, fin);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: busy=%b required 0", busy); end
    vectors++;
    if ({start_transaction, test_done, timeout_err, pass_count, fail_count, cur_idx,
         transaction_type, address, size, source, write_data, write_mask} !==
        {{(3+32+IDX_W+2+ADDR_W+SIZE_W+SOURCE_W+DW){1'b0}}, 8'hFF}) begin
      miscompares++;
      $display("FAIL rstmid_outputs: addr=%h data=%h mask=%h idx=%0d required 0 0 ff 0", address, write_data, write_mask, cur_idx);
    end
    rst_n = 1'b1; resp_on = 1'b1;
    exp_q.push_back(shadow[0]);
    run_seq(200, -1, fin);
    vectors++;
    if (!fin || obs_q.size() != 2) begin miscompares++; $display("FAIL rstmid_pulses: finished=%0d pulses=%0d required 1 2", fin, obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rstmid_txn: got %h required %h", o, e); end
    end
    vectors++;
    if (pass_count !== 16'd1 || fail_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rstmid_result: pass=%0d fail=%0d required 1 0", pass_count, fail_count);
    end
    obs_q.delete(); exp_q.delete(); gap_q.delete();
  endtask

  task automatic test_init_and_cfg_lock;
    bit fin;
    int early;
    txn_t o, e;
    program_entry(0, TX_PUTFULL, 32'h6000, 64'hA5A5A5A55A5A5A5A, 8'hFF);
    num_entries = 5'd1; loops = 8'd1; mem_init_done = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    early = 0;
    // Overwrite attempts while the sequence waits for memory init
    cfg_we = 1'b1; cfg_idx = '0; cfg_type = TX_GET; cfg_addr = 32'h7777;
    cfg_data = 64'hFFFF0000FFFF0000; cfg_mask = 8'h01;
    repeat (8) begin @(negedge clk); if (start_transaction === 1'b1) early++; end
    cfg_we = 1'b0;
    vectors++;
    if (early != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL init_hold: pulses=%0d busy=%b required 0 1", early, busy);
    end
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(shadow[0]);
      run_seq(200, -1, fin);
      vectors++;
      if (!fin || obs_q.size() != 1) begin miscompares++; $display("FAIL lock_pulses%0d: finished=%0d pulses=%0d required 1 1", r, fin, obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
        if (o !== e) begin miscompares++; $display("FAIL lock_txn%0d: got %h required %h", r, o, e); end
      end
      obs_q.delete(); exp_q.delete(); gap_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_zero_entries();
    test_masked_get();
    test_timeout();
    test_loops();
    test_reset_mid();
    test_init_and_cfg_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
